// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the 32-bit UART bridge write port.
// Each owner sends a header word and then `len` payload words. A stall
// watchdog pads and closes packets whose owner stops supplying data.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SYS_DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned STALL_LIMIT    = 1024
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]        req_len,
    input  logic [NUM_REQ*SYS_DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                  req_data_valid,
    output logic [NUM_REQ-1:0]                  req_data_ready,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                busy,
    output logic                                err_stall,
    output logic [SYS_DATA_WIDTH-1:0]           sys_write_data,
    output logic                                sys_write_data_valid,
    input  logic                                sys_write_data_permitted
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } state_e;

    state_e                      state_q;
    logic [NUM_REQ-1:0]          grant_q;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            rr_ptr_q;
    logic [LEN_WIDTH-1:0]        remain_q;
    logic [STALL_W-1:0]          stall_q;
    logic [SYS_DATA_WIDTH-1:0]   wdata_q;
    logic                        wvalid_q;
    logic                        err_q;

    logic [IDX_W-1:0]            cand_idx;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_vld;
    logic [LEN_WIDTH-1:0]        pick_len;
    logic [SYS_DATA_WIDTH-1:0]   g_data;
    logic                        g_valid;
    logic                        xfer;
    logic [IDX_W-1:0]            rr_next;

    // Round-robin pick: first set request scanning upward from rr_ptr with wrap
    always_comb begin
        cand_idx = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Length field of the picked requester
    always_comb begin
        pick_len = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_len = req_len[k*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Payload word and valid of the current owner
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (idx_q == IDX_W'(k)) begin
                g_data  = req_data[k*SYS_DATA_WIDTH +: SYS_DATA_WIDTH];
                g_valid = req_data_valid[k];
            end
        end
    end

    // A payload word moves only in PAYLOAD with FIFO headroom and owner data
    assign xfer           = (state_q == ST_PAYLOAD) && sys_write_data_permitted && g_valid;
    assign req_data_ready = xfer ? grant_q : '0;

    // Pointer advances past the owner when its packet completes
    assign rr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    // Packet FSM with registered write port, grant and stall pulse
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            remain_q <= '0;
            stall_q  <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q  <= NUM_REQ'(1) << pick_idx;
                        idx_q    <= pick_idx;
                        remain_q <= pick_len;
                        state_q  <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (sys_write_data_permitted) begin
                        wdata_q  <= SYS_DATA_WIDTH'({8'hA5, 8'(idx_q), 16'(remain_q)});
                        wvalid_q <= 1'b1;
                        if (remain_q == '0) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_next;
                            state_q  <= ST_IDLE;
                        end else begin
                            stall_q <= '0;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        wdata_q  <= g_data;
                        wvalid_q <= 1'b1;
                        remain_q <= remain_q - LEN_WIDTH'(1);
                        stall_q  <= '0;
                        if (remain_q == LEN_WIDTH'(1)) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_next;
                            state_q  <= ST_IDLE;
                        end
                    end else if (sys_write_data_permitted) begin
                        // Only cycles with headroom count toward the watchdog
                        if (stall_q == STALL_W'(STALL_LIMIT - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_PAD;
                        end else begin
                            stall_q <= stall_q + STALL_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    if (sys_write_data_permitted) begin
                        wdata_q  <= '0;
                        wvalid_q <= 1'b1;
                        remain_q <= remain_q - LEN_WIDTH'(1);
                        if (remain_q == LEN_WIDTH'(1)) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_next;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant                = grant_q;
    assign busy                 = (state_q != ST_IDLE);
    assign err_stall            = err_q;
    assign sys_write_data       = wdata_q;
    assign sys_write_data_valid = wvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vectors, corner-case
// sequences and a randomized run against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [NR-1:0]   req;
    logic [NR*16-1:0] req_len;
    logic [NR*32-1:0] req_data;
    logic [NR-1:0]   req_data_valid;
    logic [NR-1:0]   req_data_ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            err_stall;
    logic [31:0]     sys_write_data;
    logic            sys_write_data_valid;
    logic            sys_write_data_permitted;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .SYS_DATA_WIDTH(32), .LEN_WIDTH(16), .STALL_LIMIT(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .req_len(req_len),
        .req_data(req_data), .req_data_valid(req_data_valid),
        .req_data_ready(req_data_ready), .grant(grant), .busy(busy),
        .err_stall(err_stall), .sys_write_data(sys_write_data),
        .sys_write_data_valid(sys_write_data_valid),
        .sys_write_data_permitted(sys_write_data_permitted)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc_n = 0;
    int          cnt[NR];
    logic [15:0] lens[NR];
    logic [31:0] got[$];
    int          got_at[$];
    int          err_n, err_at, rdy_n;

    // Payload word k of requester i; top byte never equals the header marker
    function automatic logic [31:0] word_of(int i, int c);
        return {8'(i + 1), 24'(c * 40503 + 7)};
    endfunction

    assign req_len  = {lens[3], lens[2], lens[1], lens[0]};
    assign req_data = {word_of(3, cnt[3]), word_of(2, cnt[2]),
                       word_of(1, cnt[1]), word_of(0, cnt[0])};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, act, want, cyc_n);
        end
    endtask

    // One clock: called just after a falling edge with inputs already driven
    task automatic cyc();
        logic [NR-1:0] rdy_s, gnt_s;
        logic          perm_s, rst_s;
        #4;
        rdy_s  = req_data_ready;
        gnt_s  = grant;
        perm_s = sys_write_data_permitted;
        rst_s  = sys_rst_n;
        @(posedge sys_clk);
        #1;
        cyc_n++;
        if (rst_s) begin
            for (int i = 0; i < NR; i++) if (rdy_s[i]) cnt[i]++;
            if (rdy_s != '0) rdy_n++;
            chk("ready_within_grant", 32'(rdy_s & ~gnt_s), 32'd0);
        end
        if (sys_write_data_valid) begin
            got.push_back(sys_write_data);
            got_at.push_back(cyc_n);
            chk("valid_needs_permit", 32'(perm_s), 32'd1);
        end
        if (err_stall) begin
            err_n++;
            err_at = cyc_n;
        end
        @(negedge sys_clk);
    endtask

    task automatic clear_mon();
        got.delete();
        got_at.delete();
        err_n = 0;
        err_at = -1;
        rdy_n = 0;
    endtask

    task automatic wait_idle(int bound, output int at);
        int n = 0;
        while (busy && n < bound) begin
            cyc();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        at = cyc_n;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req = '0;
        req_data_valid = '0;
        sys_write_data_permitted = 1'b1;
        cyc();
        cyc();
        sys_rst_n = 1'b1;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        clear_mon();
    endtask

    typedef struct {
        int          idx;
        logic [15:0] len;
        logic [31:0] hdr;
    } vec_t;

    vec_t        vt[4];
    logic [31:0] exp_rr[3];
    logic [31:0] expq[$];
    logic [31:0] hdrs[$];
    int          mcnt[NR];
    int          n0, base, at, t2, exp_ptr, p;
    logic [3:0]  s_mask;

    initial begin
        sys_rst_n = 1'b0;
        req = '0;
        req_data_valid = '0;
        sys_write_data_permitted = 1'b1;
        for (int i = 0; i < NR; i++) begin
            lens[i] = '0;
            cnt[i] = 0;
        end
        @(negedge sys_clk);
        do_reset();

        // Reset values
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_stall), 32'd0);
        chk("rst_data", sys_write_data, 32'd0);
        chk("rst_valid", 32'(sys_write_data_valid), 32'd0);
        chk("rst_ready", 32'(req_data_ready), 32'd0);

        // Table of single full-rate packets
        vt[0] = '{0, 16'd3, 32'hA500_0003};
        vt[1] = '{2, 16'd2, 32'hA502_0002};
        vt[2] = '{1, 16'd0, 32'hA501_0000};
        vt[3] = '{3, 16'd1, 32'hA503_0001};
        for (int v = 0; v < 4; v++) begin
            clear_mon();
            base = cnt[vt[v].idx];
            lens[vt[v].idx] = vt[v].len;
            req_data_valid = '1;
            sys_write_data_permitted = 1'b1;
            n0 = cyc_n;
            req = NR'(1) << vt[v].idx;
            cyc();
            req = '0;
            chk("tbl_grant", 32'(grant), 32'(NR'(1) << vt[v].idx));
            wait_idle(40, at);
            chk("tbl_words", got.size(), 32'(vt[v].len) + 1);
            if (got.size() > 0) begin
                chk("tbl_header", got[0], vt[v].hdr);
                chk("tbl_first_at", got_at[0], n0 + 2);
                chk("tbl_last_at", got_at[got_at.size()-1], n0 + 2 + int'(vt[v].len));
            end
            for (int j = 1; j < got.size(); j++)
                chk("tbl_payload", got[j], word_of(vt[v].idx, base + j - 1));
            chk("tbl_busy_low_at", at, n0 + 2 + int'(vt[v].len));
        end

        // Round-robin: 1 and 2 together, then 1 alone
        do_reset();
        lens[1] = 16'd1;
        lens[2] = 16'd1;
        req_data_valid = '1;
        req = 4'b0110;
        hdrs.delete();
        for (int n = 0; n < 60 && hdrs.size() < 3; n++) begin
            cyc();
            if (grant[2]) req[2] = 1'b0;
            hdrs.delete();
            foreach (got[k]) if (got[k][31:24] == 8'hA5) hdrs.push_back(got[k]);
        end
        req = '0;
        wait_idle(40, at);
        exp_rr[0] = 32'hA501_0001;
        exp_rr[1] = 32'hA502_0001;
        exp_rr[2] = 32'hA501_0001;
        chk("rr_hdr_count", hdrs.size(), 32'd3);
        for (int k = 0; k < 3 && k < hdrs.size(); k++) chk("rr_order", hdrs[k], exp_rr[k]);
        chk("rr_words", got.size(), 32'd6);

        // Zero length from requester 3, then rr_ptr must wrap to 0
        clear_mon();
        lens[3] = 16'd0;
        req = 4'b1000;
        cyc();
        req = '0;
        chk("zl_grant", 32'(grant), 32'b1000);
        cyc();
        chk("zl_words", got.size(), 32'd1);
        if (got.size() > 0) chk("zl_header", got[0], 32'hA503_0000);
        chk("zl_grant_clear", 32'(grant), 32'd0);
        chk("zl_busy", 32'(busy), 32'd0);
        req = '1;
        cyc();
        req = '0;
        chk("zl_rr_wrap", 32'(grant), 32'b0001);
        wait_idle(40, at);

        // Backpressure: permitted low for 20 cycles after the second word
        clear_mon();
        lens[0] = 16'd4;
        base = cnt[0];
        req = 4'b0001;
        cyc();
        req = '0;
        for (int n = 0; n < 30 && got.size() < 3; n++) cyc();
        sys_write_data_permitted = 1'b0;
        rdy_n = 0;
        n0 = got.size();
        repeat (20) cyc();
        chk("bp_no_ready", rdy_n, 32'd0);
        chk("bp_no_valid", got.size(), n0);
        chk("bp_no_err", err_n, 32'd0);
        sys_write_data_permitted = 1'b1;
        wait_idle(40, at);
        chk("bp_words", got.size(), 32'd5);
        for (int j = 1; j < got.size(); j++) chk("bp_payload", got[j], word_of(0, base + j - 1));
        chk("bp_err_after", err_n, 32'd0);

        // Stall pad: owner stops after two words with permitted high
        clear_mon();
        lens[1] = 16'd5;
        base = cnt[1];
        req = 4'b0010;
        cyc();
        req = '0;
        for (int n = 0; n < 20 && cnt[1] - base < 2; n++) cyc();
        req_data_valid[1] = 1'b0;
        t2 = cyc_n;
        for (int n = 0; n < 40 && err_n == 0; n++) cyc();
        req_data_valid[1] = 1'b1;
        rdy_n = 0;
        wait_idle(40, at);
        chk("pad_err_count", err_n, 32'd1);
        chk("pad_err_at", err_at, t2 + 16);
        chk("pad_no_ready", rdy_n, 32'd0);
        chk("pad_words", got.size(), 32'd6);
        for (int j = 3; j < got.size(); j++) chk("pad_zero", got[j], 32'd0);
        if (got.size() == 6) chk("pad_last_at", got_at[5], err_at + 3);
        chk("pad_idle_at", at, err_at + 3);

        // Reset in the middle of a payload
        clear_mon();
        lens[2] = 16'd8;
        req = 4'b0100;
        cyc();
        req = '0;
        for (int n = 0; n < 20 && got.size() < 3; n++) cyc();
        sys_rst_n = 1'b0;
        cyc();
        chk("mr_grant", 32'(grant), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_err", 32'(err_stall), 32'd0);
        chk("mr_data", sys_write_data, 32'd0);
        chk("mr_valid", 32'(sys_write_data_valid), 32'd0);
        chk("mr_ready", 32'(req_data_ready), 32'd0);
        sys_rst_n = 1'b1;
        req = '1;
        cyc();
        req = '0;
        chk("mr_rr_from_0", 32'(grant), 32'b0001);
        wait_idle(40, at);

        // Randomized traffic against a packet-level model
        do_reset();
        exp_ptr = 0;
        for (int i = 0; i < NR; i++) mcnt[i] = 0;
        for (int r = 0; r < 4; r++) begin
            s_mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) lens[i] = 16'($urandom_range(0, 6));
            clear_mon();
            req = s_mask;
            repeat (300) begin
                for (int i = 0; i < NR; i++) req_data_valid[i] = ($urandom_range(0, 7) != 0);
                sys_write_data_permitted = ($urandom_range(0, 3) != 0);
                cyc();
            end
            req = '0;
            req_data_valid = '1;
            sys_write_data_permitted = 1'b1;
            wait_idle(200, at);
            expq.delete();
            while (expq.size() < got.size()) begin
                p = -1;
                for (int k = 0; k < NR && p < 0; k++)
                    if (s_mask[(exp_ptr + k) % NR]) p = (exp_ptr + k) % NR;
                expq.push_back({8'hA5, 8'(p), lens[p]});
                for (int j = 0; j < int'(lens[p]); j++) begin
                    expq.push_back(word_of(p, mcnt[p]));
                    mcnt[p]++;
                end
                exp_ptr = (p + 1) % NR;
            end
            chk("rand_count", got.size(), expq.size());
            for (int k = 0; k < got.size() && k < expq.size(); k++)
                chk("rand_word", got[k], expq[k]);
            chk("rand_no_err", err_n, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
